// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared op-field positions, size encodings and FSM states
package mem_access_ctrl_pkg;
  localparam int OP_WR  = 3;
  localparam int OP_UNS = 2;
  localparam int OP_SZ  = 0;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_LAST, S_WR, S_DONE} state_t;
  // index of the last byte of an access; sizes 2 and 3 are both a word
  function automatic logic [1:0] last_k(input logic [1:0] sz);
    return sz == SZ_B ? 2'd0 : sz == SZ_H ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: fixed-priority arbiter, lowest index wins
//   i_req  request vector
//   o_gnt  one-hot grant
//   o_idx  binary index of the granted channel
//   o_any  any request present
module mem_arb_prio #(
  parameter int NCH = 2,
  parameter int IW  = NCH > 1 ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_req,
  output logic [NCH-1:0] o_gnt,
  output logic [IW-1:0]  o_idx,
  output logic           o_any
);
  assign o_gnt = i_req & (~i_req + NCH'(1));
  assign o_any = |i_req;
  always_comb begin
    o_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) o_idx = i_req[i] ? IW'(i) : o_idx;
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: serialises multi-channel byte/half/word loads and stores onto a byte-wide RAM bus
//   clk, rst      clock, async active-high reset
//   rdy           global ready; low freezes the controller
//   ch_*          per-channel request, op {wr,uns,size}, address, store data, read flush
//   ch_done       one-cycle completion pulse; rdata valid alongside for reads
//   busy          controller not idle
//   ram_*         byte-wide RAM bus; ram_din answers the previous rdy cycle's address
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int NCH  = 2,
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic [NCH-1:0]     ch_req,
  input  logic [NCH*4-1:0]   ch_op,
  input  logic [NCH*AW-1:0]  ch_addr,
  input  logic [NCH*XLEN-1:0] ch_wdata,
  input  logic [NCH-1:0]     ch_flush,
  output logic [NCH-1:0]     ch_done,
  output logic [XLEN-1:0]    rdata,
  output logic               busy,
  input  logic [7:0]         ram_din,
  output logic [7:0]         ram_dout,
  output logic [AW-1:0]      ram_a,
  output logic               ram_wr
);
  localparam int IW = NCH > 1 ? $clog2(NCH) : 1;
  state_t          r_state;
  logic [NCH-1:0]  r_gnt;
  logic            r_uns;
  logic [1:0]      r_sz;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_bytes;
  logic [1:0]      r_k;
  logic            r_pend;
  logic [NCH-1:0]  w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_flush;
  logic [1:0]      w_last;
  logic            w_sgn;
  logic [XLEN-1:0] w_word;
  logic [XLEN-1:0] w_ext;
  logic [3:0]      w_op;

  mem_arb_prio #(.NCH(NCH), .IW(IW)) u_arb (
    .i_req(ch_req),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  assign w_op    = ch_op[4*w_idx +: 4];
  assign w_last  = last_k(r_sz);
  assign w_flush = |(ch_flush & r_gnt);

  // r_pend marks that the previous rdy cycle issued a read, so ram_din now holds byte k-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_uns   <= 1'b0;
      r_sz    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_bytes <= '0;
      r_k     <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (rdy && w_any) begin
          r_gnt   <= w_gnt;
          r_uns   <= w_op[OP_UNS];
          r_sz    <= w_op[OP_SZ +: 2];
          r_addr  <= ch_addr[AW*w_idx +: AW];
          r_wdata <= ch_wdata[XLEN*w_idx +: 32];
          r_bytes <= '0;
          r_k     <= '0;
          r_pend  <= 1'b0;
          r_state <= w_op[OP_WR] ? S_WR : S_RD;
        end
        S_RD: if (w_flush) r_state <= S_IDLE;
        else if (rdy) begin
          if (r_pend) r_bytes[8*(r_k-2'd1) +: 8] <= ram_din;
          r_pend <= 1'b1;
          if (r_k == w_last) r_state <= S_RD_LAST;
          else r_k <= r_k + 2'd1;
        end
        S_RD_LAST: if (w_flush) r_state <= S_IDLE;
        else if (rdy) begin
          r_bytes[8*r_k +: 8] <= ram_din;
          r_state <= S_DONE;
        end
        S_WR: if (rdy) begin
          if (r_k == w_last) r_state <= S_DONE;
          else r_k <= r_k + 2'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // words always sign-extend; the unsigned flag only matters for bytes and halves
  assign w_sgn  = ~r_uns & (r_sz == SZ_B ? r_bytes[7] : r_bytes[15]);
  assign w_word = XLEN'(signed'(r_bytes));
  assign w_ext  = r_sz == SZ_B ? {{(XLEN-8){w_sgn}}, r_bytes[7:0]}
                : r_sz == SZ_H ? {{(XLEN-16){w_sgn}}, r_bytes[15:0]} : w_word;

  assign busy     = r_state != S_IDLE;
  assign ch_done  = r_state == S_DONE ? r_gnt : '0;
  assign rdata    = r_state == S_DONE ? w_ext : '0;
  assign ram_a    = (r_state == S_RD || r_state == S_WR) ? r_addr + AW'(r_k) : '0;
  assign ram_wr   = r_state == S_WR && rdy;
  assign ram_dout = r_state == S_WR ? r_wdata[8*r_k +: 8] : 8'd0;
endmodule
